serial_frame_rx: RTL and testbench

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

---
 rtl/serial_frame_rx.sv | 142 ++++++++++++++
 tb/tb_serial_frame_rx.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Serial packet receiver: one bit per clk, frames are start(0), type, payload
// MSB first, stop(1). Good frames land in a first-word-fall-through FIFO;
// bad stop bits pulse frame_err and resync on the next idle-high bit.
module serial_frame_rx #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_is_cmd,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_TYPE, S_PAYLOAD, S_STOP, S_RESYNC
  } state_t;

  typedef struct packed {
    logic              is_cmd;
    logic [DATA_W-1:0] data;
  } pkt_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     bit_cnt;
  logic              type_q;
  logic [DATA_W-1:0] payload_q;
  logic              push_req, ferr_set;
  logic              last_bit;

  pkt_t              mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic              full, pop, push_ok;
  pkt_t              head;

  assign last_bit = (bit_cnt == CW'(DATA_W-1));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: walk the frame fields one bit per clock
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (!sin) state_nxt = S_TYPE;
      S_TYPE:    state_nxt = S_PAYLOAD;
      S_PAYLOAD: if (last_bit) state_nxt = S_STOP;
      S_STOP:    state_nxt = sin ? S_IDLE : S_RESYNC;
      S_RESYNC:  if (sin) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: stop-bit verdict
  always_comb begin
    push_req = 1'b0;
    ferr_set = 1'b0;
    if (state == S_STOP) begin
      push_req = sin;
      ferr_set = !sin;
    end
  end

  // Frame datapath: type latch, payload shifter, bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_q    <= 1'b0;
      payload_q <= '0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        S_TYPE: begin
          type_q  <= sin;
          bit_cnt <= '0;
        end
        S_PAYLOAD: begin
          payload_q <= (payload_q << 1) | DATA_W'(sin);
          bit_cnt   <= bit_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // FIFO control; a full FIFO still accepts a push when the head leaves the same edge
  assign full    = (level == LW'(FIFO_DEPTH));
  assign pop     = out_valid && out_ready;
  assign push_ok = push_req && (!full || pop);

  // FIFO storage, not reset: the output is gated by out_valid instead
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= '{is_cmd: type_q, data: payload_q};
  end

  // FIFO pointers (natural wrap on power-of-2 depth) and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // One-cycle event pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      overflow  <= push_req && full && !pop;
    end
  end

  assign head       = mem[rd_ptr];
  assign out_valid  = (level != '0);
  assign out_data   = out_valid ? head.data : '0;
  assign out_is_cmd = out_valid && head.is_cmd;
  assign fifo_level = level;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Randomized bench for serial_frame_rx. The reference model is a packet
// queue updated per clock from what the driver sent: a good stop bit enqueues
// the packet (or flags overflow), a bad one flags frame_err, ready pops.
module tb_serial_frame_rx;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sin;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_is_cmd;
  logic              frame_err;
  logic              overflow;
  logic [2:0]        fifo_level;

  serial_frame_rx #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_is_cmd(out_is_cmd), .frame_err(frame_err), .overflow(overflow),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_err = 0;
  logic [8:0] q[$];      // {is_cmd, data}
  logic [8:0] cur_pkt;
  int         rdy_mode;  // 0: never ready, 1: always, 2: random
  logic       exp_ferr, exp_ovf;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("fifo_level", int'(fifo_level), q.size());
    chk("out_valid", int'(out_valid), int'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_data", int'(out_data), int'(q[0][7:0]));
      chk("out_is_cmd", int'(out_is_cmd), int'(q[0][8]));
    end
    chk("frame_err", int'(frame_err), int'(exp_ferr));
    chk("overflow", int'(overflow), int'(exp_ovf));
  endtask

  // ev: 0 plain bit, 1 good stop bit carrying cur_pkt, 2 bad stop bit
  task automatic tick(input logic s, input int ev, input int rdy_force);
    logic rdy;
    bit   pop, full;
    if (rdy_force >= 0)     rdy = rdy_force[0];
    else if (rdy_mode == 2) rdy = 1'($urandom_range(0, 1));
    else                    rdy = rdy_mode[0];
    sin       = s;
    out_ready = rdy;
    @(posedge clk);
    #1;
    full     = (q.size() == FIFO_DEPTH);
    pop      = (q.size() != 0) && rdy;
    exp_ferr = (ev == 2);
    exp_ovf  = 1'b0;
    if (pop) q.delete(0);
    if (ev == 1) begin
      if (full && !pop) exp_ovf = 1'b1;
      else              q.push_back(cur_pkt);
    end
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 0, -1);
  endtask

  task automatic send_frame(input logic t, input logic [7:0] d,
                            input logic stop_ok, input int stop_rdy);
    tick(1'b0, 0, -1);
    tick(t, 0, -1);
    for (int i = 7; i >= 0; i--) tick(d[i], 0, -1);
    cur_pkt = {t, d};
    tick(stop_ok, stop_ok ? 1 : 2, stop_rdy);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_level"}, int'(fifo_level), 0);
    chk({tag, "_data"}, int'(out_data), 0);
    chk({tag, "_cmd"}, int'(out_is_cmd), 0);
    chk({tag, "_ferr"}, int'(frame_err), 0);
    chk({tag, "_ovf"}, int'(overflow), 0);
  endtask

  initial begin
    logic [7:0] d;
    logic       t, ok;
    rst_n = 1'b0; sin = 1'b1; out_ready = 1'b0; rdy_mode = 0;
    exp_ferr = 1'b0; exp_ovf = 1'b0;
    #1;
    check_reset_outputs("rst");
    #20 rst_n = 1'b1;
    idle(2);

    // single DATA 0xA5, then pop it
    send_frame(1'b0, 8'hA5, 1'b1, -1);
    rdy_mode = 1;
    idle(2);

    // bad stop, low line held, then recovery with DATA 0x11
    rdy_mode = 0;
    send_frame(1'b1, 8'h3C, 1'b0, -1);
    for (int i = 0; i < 3; i++) tick(1'b0, 0, -1);
    idle(1);
    send_frame(1'b0, 8'h11, 1'b1, -1);
    rdy_mode = 1;
    idle(2);

    // five back-to-back into a four-deep FIFO with no consumer: one overflow
    rdy_mode = 0;
    for (int i = 1; i <= 5; i++) send_frame(1'b0, 8'(i), 1'b1, -1);
    rdy_mode = 1;
    idle(6);

    // full FIFO, pop on the fifth stop edge: no overflow
    rdy_mode = 0;
    for (int i = 1; i <= 4; i++) send_frame(1'b0, 8'(i), 1'b1, -1);
    send_frame(1'b0, 8'h05, 1'b1, 1);
    rdy_mode = 1;
    idle(6);

    // reset mid-packet with a packet waiting in the FIFO
    rdy_mode = 0;
    send_frame(1'b0, 8'h5A, 1'b1, -1);
    tick(1'b0, 0, -1); tick(1'b1, 0, -1);
    tick(1'b1, 0, -1); tick(1'b0, 0, -1); tick(1'b1, 0, -1);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    exp_ferr = 1'b0; exp_ovf = 1'b0;
    check_reset_outputs("async_rst");
    sin = 1'b1;
    #3 rst_n = 1'b1;
    idle(1);
    send_frame(1'b1, 8'hFF, 1'b1, -1);
    rdy_mode = 1;
    idle(2);

    // CMD then DATA with no idle bit between
    rdy_mode = 0;
    send_frame(1'b1, 8'h80, 1'b1, -1);
    send_frame(1'b0, 8'h7F, 1'b1, -1);
    rdy_mode = 1;
    idle(3);

    // random frames, gaps, stop errors and consumer pressure
    rdy_mode = 2;
    for (int n = 0; n < 150; n++) begin
      d  = 8'($urandom);
      t  = 1'($urandom_range(0, 1));
      ok = ($urandom_range(0, 7) != 0);
      send_frame(t, d, ok, -1);
      idle(ok ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3)));
    end
    rdy_mode = 1;
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
